// File: rtl/io_bus_responder.sv
// Memory-mapped IO responder: 256x16 RAM, LED register, synchronised switches, optional cycle counter.
// Optional cycle counter on page 0x2 is compiled in with `define IO_BUS_TIMER_EN.
module io_bus_responder (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic [15:0] ADDR,
  input  logic [15:0] DOUT,
  input  logic        W,
  output logic [15:0] DIN,
  output logic [9:0]  LEDR,
  input  logic [9:0]  SW
);

  logic [15:0] ram [256];
  logic [9:0]  sw_meta, sw_sync;
  logic [15:0] rd_data;
  logic        ram_hit, led_hit;

  // RAM lives only at 0x0000-0x00FF; 0x0100-0x0FFF is a hole, not an alias.
  assign ram_hit = (ADDR[15:8] == 8'h00);
  assign led_hit = (ADDR[15:12] == 4'h1);

`ifdef IO_BUS_TIMER_EN
  logic [15:0] cnt;
  logic        cnt_hit;
  assign cnt_hit = (ADDR[15:12] == 4'h2);

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn)            cnt <= '0;
    else if (W && cnt_hit)  cnt <= '0;
    else                    cnt <= cnt + 16'd1;
  end
`endif

  always_comb begin
    rd_data = '0;
    unique case (ADDR[15:12])
      4'h0: if (ADDR[11:8] == 4'h0) rd_data = ram[ADDR[7:0]];
      4'h1: rd_data = {6'b0, LEDR};
`ifdef IO_BUS_TIMER_EN
      4'h2: rd_data = cnt;
`endif
      4'h3: rd_data = {6'b0, sw_sync};
      default: rd_data = '0;
    endcase
  end

  // RAM is not reset; the reset term only blocks writes while Resetn is low.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (Resetn && W && ram_hit) ram[ADDR[7:0]] <= DOUT;
  end

  // DIN captures pre-edge contents, which gives read-before-write for free.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      DIN     <= '0;
      LEDR    <= '0;
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      DIN     <= rd_data;
      sw_meta <= SW;
      sw_sync <= sw_meta;
      if (W && led_hit) LEDR <= DOUT[9:0];
    end
  end

endmodule

// File: doc/io_bus_responder.md
IO_BUS_RESPONDER -- requirements
Module: io_bus_responder

Interface
REQ-001 SHALL use one clock and an asynchronous, active-low reset: Clock input 1, rising-edge clock; Resetn input 1, asynchronous active-low reset.
REQ-002 SHALL provide the ports below, one per line as name, direction, width, meaning.
- Clock  input  1  system clock.
- Resetn  input  1  asynchronous active-low reset.
- ADDR  input  16  processor address, sampled every rising edge.
- DOUT  input  16  processor write data.
- W  input  1  write strobe; 1 = write DOUT to ADDR this edge.
- DIN  output  16  read data returned to processor, registered.
- LEDR  output  10  LED register contents.
- SW  input  10  asynchronous switch inputs.

Function
REQ-003 SHALL decode ADDR[15:12] as follows:
- 0x0 with ADDR[11:8]=0: RAM, 256x16, index ADDR[7:0].
- 0x1: LED register.
- 0x2: cycle counter.
- 0x3: switch port.
- anything else: unmapped.
REQ-004 SHALL have read latency exactly 1 cycle: DIN at edge N+1 reflects the ADDR sampled at edge N, regardless of W.
REQ-005 SHALL make RAM read-before-write: a write and a read of the same RAM word on the same edge returns the old word on DIN.
REQ-006 SHALL write DOUT into RAM[ADDR[7:0]] on an edge with W=1 and a RAM hit.
REQ-007 SHALL load DOUT[9:0] into LEDR on an edge with W=1 and an LED hit; LEDR updates the cycle after the write edge.
REQ-008 SHALL return {6'b0, LEDR} on an LED read.
REQ-009 SHALL synchronise SW through two flip-flop stages.
REQ-010 SHALL return {6'b0, synchronised SW} on a switch read; writes to the switch port are ignored.
REQ-011 SHALL return 16'h0000 for unmapped reads and ignore unmapped writes, with no side effects.
REQ-012 SHALL use 0x0100-0x0FFF as unmapped space; it does not alias RAM.
REQ-013 SHALL implement the cycle counter (when compiled in) as a 16-bit free-running counter, +1 per edge, wrapping 0xFFFF -> 0x0000.
REQ-014 SHALL clear the cycle counter when W=1 hits it; on the same edge the clear wins over the increment, so the counter reads 0x0000 after that edge.
REQ-015 SHALL return on DIN, for a counter read, the value the counter held at the sampling edge.
REQ-016 SHALL take the next-edge value on DIN when ADDR changes every cycle (back-to-back accesses); there are no wait states and no handshake beyond W.

Reset
REQ-017 SHALL, while Resetn=0, force DIN=0, LEDR=0, cycle counter=0 and both SW synchroniser stages=0, immediately (asynchronously).
REQ-018 SHALL leave RAM contents unchanged by reset.
REQ-019 SHALL block all writes while Resetn=0.
REQ-020 SHALL, if reset is asserted mid-write, guarantee only that the write either completed before assertion or did not occur; LEDR is 0 regardless.
REQ-021 SHALL, on the first edge after Resetn rises, resume normal decode; the counter reads 0x0001 one edge later.

Configuration
REQ-022 SHALL compile the cycle counter in when macro IO_BUS_TIMER_EN is defined: behaviour per REQ-013..REQ-015.
REQ-023 SHALL, when IO_BUS_TIMER_EN is undefined, contain no counter register; page 0x2 behaves as unmapped (reads 0x0000, writes ignored).

Verification
REQ-024 SHALL cover a RAM write then read: W=1 ADDR=0x0005 DOUT=0xBEEF, then ADDR=0x0005 W=0 -> DIN=0xBEEF one cycle later; ADDR=0x0105 -> DIN=0x0000.
REQ-025 SHALL cover read-before-write: RAM[0x10]=0x1111; same edge W=1 ADDR=0x0010 DOUT=0x2222 -> DIN=0x1111; next read -> 0x2222.
REQ-026 SHALL cover LED/SW: write 0xFFFF to 0x1000 -> LEDR=0x3FF and a read of 0x1000 gives 0x03FF; SW=0x155 held, read 0x3000 on the third edge or later -> DIN=0x0155.
REQ-027 SHALL cover the counter (IO_BUS_TIMER_EN): write to 0x2000, read 0x2000 on the following 3 edges -> DIN=0x0000, 0x0001, 0x0002; preload by running 65536 cycles -> wraps to 0x0000.
REQ-028 SHALL cover reset mid-run: LEDR=0x2AA, counter nonzero, assert Resetn=0 between edges -> LEDR=0, DIN=0 immediately; RAM[0x05] still 0xBEEF after release.
REQ-029 SHALL cover the build without IO_BUS_TIMER_EN: write then read 0x2000 -> DIN=0x0000 every cycle.
